// File: rtl/code_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : code_serializer_if
//  Description : Frame request / serial output bundle for code_serializer.
//                The master drives start/code/len/abort, the slave (the
//                serializer) drives dout/valid/busy/done.
//  Revision    : 1.0 - initial release
// ============================================================================
interface code_serializer_if #(
   parameter int WIDTH = 8
) ();
   logic                       start;
   logic [WIDTH-1:0]           code;
   logic [$clog2(WIDTH+1)-1:0] len;
   logic                       abort;
   logic                       dout;
   logic                       valid;
   logic                       busy;
   logic                       done;

   modport master (
      output start, code, len, abort,
      input  dout, valid, busy, done
   );

   modport slave (
      input  start, code, len, abort,
      output dout, valid, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/code_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : code_serializer
//  Description : Sends a captured code of 1..WIDTH bits MSB first on a
//                registered serial line, optionally followed by an even
//                parity bit, then GAP_CYCLES idle-low cycles and a one-cycle
//                done pulse. Optional feature macro: CODE_SERIALIZER_PARITY_EN
//                (adds the parity bit after the last code bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module code_serializer #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  wire logic       clk,
   input  wire logic       arst,
   code_serializer_if.slave bus
);

   localparam int c_LEN_W   = $clog2(WIDTH + 1);
   localparam int c_CNT_MAX = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
`ifdef CODE_SERIALIZER_PARITY_EN
      S_PARITY = 2'd2,
`endif
      S_GAP    = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     code_q,  code_d;
   // In SHIFT: index of the bit currently on dout. In GAP: cycles left - 1.
   logic [c_CNT_W-1:0]   cnt_q,   cnt_d;
   logic                 dout_q,  dout_d;
   logic                 valid_q, valid_d;
   logic                 busy_q,  busy_d;
   logic                 done_q,  done_d;
`ifdef CODE_SERIALIZER_PARITY_EN
   logic                 par_q,   par_d;
`endif

   logic [c_LEN_W-1:0]   w_len_cl;
   logic [WIDTH-1:0]     w_in_shift;
   logic [WIDTH-1:0]     w_q_shift;
   logic                 w_finish;

   // Oversized lengths are clamped to the register width at capture.
   assign w_len_cl   = (bus.len > c_LEN_W'(WIDTH)) ? c_LEN_W'(WIDTH) : bus.len;
   // Shifts give the selected bit in position 0 without a wide bit-select.
   assign w_in_shift = bus.code >> (w_len_cl - c_LEN_W'(1));
   assign w_q_shift  = code_q >> (cnt_q - c_CNT_W'(1));

   // Next-state and next-output logic; outputs are registered from these.
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      dout_d   = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      w_finish = 1'b0;
`ifdef CODE_SERIALIZER_PARITY_EN
      par_d    = par_q;
`endif

      case (state_q)
         S_IDLE: begin
            // abort beats start even while idle
            if (bus.start && !bus.abort && (bus.len != '0)) begin
               state_d = S_SHIFT;
               code_d  = bus.code;
               cnt_d   = c_CNT_W'(w_len_cl) - c_CNT_W'(1);
               dout_d  = w_in_shift[0];
               valid_d = 1'b1;
               busy_d  = 1'b1;
`ifdef CODE_SERIALIZER_PARITY_EN
               par_d   = w_in_shift[0];
`endif
            end
         end

         S_SHIFT: begin
            busy_d = 1'b1;
            if (cnt_q == '0) begin
`ifdef CODE_SERIALIZER_PARITY_EN
               state_d = S_PARITY;
               dout_d  = par_q;
               valid_d = 1'b1;
`else
               w_finish = 1'b1;
`endif
            end else begin
               cnt_d   = cnt_q - c_CNT_W'(1);
               dout_d  = w_q_shift[0];
               valid_d = 1'b1;
`ifdef CODE_SERIALIZER_PARITY_EN
               par_d   = par_q ^ w_q_shift[0];
`endif
            end
         end

`ifdef CODE_SERIALIZER_PARITY_EN
         S_PARITY: begin
            w_finish = 1'b1;
         end
`endif

         S_GAP: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d  = cnt_q - c_CNT_W'(1);
               busy_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Frame body finished: enter the idle-low gap, or finish at once.
      if (w_finish) begin
         if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end else begin
            state_d = S_GAP;
            cnt_d   = c_CNT_W'(GAP_CYCLES - 1);
            busy_d  = 1'b1;
         end
      end

      // Cancel a frame in flight: silent return to idle, no done pulse.
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         dout_d  = 1'b0;
         valid_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   // State, captured frame and registered outputs; reset wins over all.
   always_ff @(posedge clk) begin
      if (!arst) begin
         state_q <= S_IDLE;
         code_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef CODE_SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef CODE_SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.dout  = dout_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_code_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_serializer
//  Description : Self-checking bench for code_serializer. A frame-level
//                reference model turns each accepted request into the list
//                of expected output cycles and compares them every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_serializer;

   localparam int WIDTH      = 8;
   localparam int GAP_CYCLES = 2;
`ifdef CODE_SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic clk;
   logic arst;

   code_serializer_if #(.WIDTH(WIDTH)) bus ();

   code_serializer #(
      .WIDTH      (WIDTH),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_done  = 0;
   int n_valid = 0;

   // Expected output per cycle: {dout, valid, busy, done}
   logic [3:0] exp_q[$];
   logic [3:0] exp_cur = 4'b0000;
   logic [3:0] exp_nxt;

   task automatic check(input string tag, input logic act, input logic exp);
      n_cmp++;
      assert (act === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic check_int(input string tag, input int act, input int exp);
      n_cmp++;
      assert (act === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   // Expand one accepted request into its full expected cycle list.
   task automatic build_frame(input logic [7:0] c, input int l);
      int n;
      logic p;
      n = (l > WIDTH) ? WIDTH : l;
      p = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
         exp_q.push_back({c[i], 1'b1, 1'b1, 1'b0});
         p = p ^ c[i];
      end
      if (PAR == 1) exp_q.push_back({p, 1'b1, 1'b1, 1'b0});
      for (int g = 0; g < GAP_CYCLES; g++) exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0001);
   endtask

   // Decide the next cycle's expectation from the current inputs.
   task automatic model_step();
      logic idle;
      idle = ~exp_cur[1];
      if (!arst) begin
         exp_q.delete();
         exp_nxt = 4'b0000;
      end else if (!idle && bus.abort) begin
         exp_q.delete();
         exp_nxt = 4'b0000;
      end else begin
         if (idle && bus.start && !bus.abort && (bus.len != 0))
            build_frame(bus.code, int'(bus.len));
         exp_nxt = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      check("dout",  bus.dout,  exp_nxt[3]);
      check("valid", bus.valid, exp_nxt[2]);
      check("busy",  bus.busy,  exp_nxt[1]);
      check("done",  bus.done,  exp_nxt[0]);
      if (bus.done)  n_done++;
      if (bus.valid) n_valid++;
      exp_cur = exp_nxt;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One-cycle start request followed by n idle-input cycles.
   task automatic send(input logic [7:0] c, input logic [3:0] l, input int n);
      bus.start = 1'b1;
      bus.code  = c;
      bus.len   = l;
      tick();
      bus.start = 1'b0;
      run(n);
   endtask

   initial begin
      arst      = 1'b0;
      bus.start = 1'b0;
      bus.code  = '0;
      bus.len   = '0;
      bus.abort = 1'b0;
      @(negedge clk);

      // reset state, with a start request that must be ignored
      bus.start = 1'b1;
      bus.code  = 8'hFF;
      bus.len   = 4'd8;
      run(3);
      bus.start = 1'b0;
      arst = 1'b1;
      run(2);

      // 8'hCA full length, then 8'hCB (parity 1 when enabled)
      send(8'hCA, 4'd8, 14);
      send(8'hCB, 4'd8, 14);

      // short code; code/len change mid-frame must not matter
      bus.start = 1'b1; bus.code = 8'hA5; bus.len = 4'd4;
      tick();
      bus.start = 1'b0; bus.code = 8'h3C; bus.len = 4'd7;
      run(10);

      // len = 0 is ignored entirely
      n_done = 0;
      send(8'hFF, 4'd0, 6);
      check_int("len0_done_count", n_done, 0);

      // len = 12 clamps to WIDTH
      n_valid = 0;
      send(8'h96, 4'd12, 14);
      check_int("clamp_valid_count", n_valid, WIDTH + PAR);

      // start pulses at cycles 3 and 5 of a frame are ignored
      bus.start = 1'b1; bus.code = 8'h5A; bus.len = 4'd8;
      tick();
      bus.start = 1'b0;
      run(2);
      bus.start = 1'b1; bus.code = 8'hFF; bus.len = 4'd3;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      run(10);

      // start held high: back-to-back frames accepted in the done cycle
      n_done = 0;
      bus.start = 1'b1; bus.code = 8'hE1; bus.len = 4'd5;
      run(3 * (5 + PAR + GAP_CYCLES + 1));
      bus.start = 1'b0;
      run(10);
      check_int("b2b_done_count", n_done, 3);

      // abort at cycle 4 of a frame: no done pulse
      n_done = 0;
      bus.start = 1'b1; bus.code = 8'hC3; bus.len = 4'd8;
      tick();
      bus.start = 1'b0;
      run(3);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      run(12);
      check_int("abort_done_count", n_done, 0);

      // abort while idle has no effect
      bus.abort = 1'b1;
      run(2);
      bus.abort = 1'b0;

      // reset at cycle 6 of a frame, then a normal frame afterwards
      n_done = 0;
      bus.start = 1'b1; bus.code = 8'h7E; bus.len = 4'd8;
      tick();
      bus.start = 1'b0;
      run(5);
      arst = 1'b0;
      tick();
      arst = 1'b1;
      run(3);
      check_int("reset_done_count", n_done, 0);
      send(8'h81, 4'd8, 14);

      // randomized traffic, including abort and rare reset
      for (int i = 0; i < 1500; i++) begin
         bus.start = ($urandom_range(99) < 40);
         bus.code  = 8'($urandom);
         bus.len   = 4'($urandom_range(15));
         bus.abort = ($urandom_range(99) < 4);
         arst      = !($urandom_range(199) == 0);
         tick();
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      arst      = 1'b1;
      run(15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/code_serializer.md
CODE_SERIALIZER -- requirements
Module: code_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning maximum code length in bits.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning idle-low cycles inserted after each frame.
REQ-003 SHALL have port clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 SHALL have port arst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request to send one frame; sampled only while idle.
REQ-006 SHALL have port code  input  WIDTH  code pattern; captured on accepted start.
REQ-007 SHALL have port len  input  $clog2(WIDTH+1)  number of code bits to send; captured on accepted start.
REQ-008 SHALL have port abort  input  1  synchronous frame cancel.
REQ-009 SHALL have port dout  output  1  serial data line, registered.
REQ-010 SHALL have port valid  output  1  high while dout carries a frame bit.
REQ-011 SHALL have port busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on normal frame completion.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT, PARITY, GAP.
REQ-014 IDLE: start=1 and len!=0 SHALL latch code/len and enter SHIFT; start with len=0 SHALL be ignored.
REQ-015 len>WIDTH SHALL be clamped to WIDTH at capture.
REQ-016 SHIFT SHALL drive code[len-1] down to code[0], one bit per clock, MSB first, with valid=1.
REQ-017 The first frame bit SHALL appear on dout in the first cycle after the start-sampling edge.
REQ-018 After the last code bit, SHIFT SHALL go to PARITY if it is enabled, else to GAP; with GAP_CYCLES=0 it SHALL go directly to IDLE.
REQ-019 GAP SHALL hold dout=0 and valid=0 with busy=1 for exactly GAP_CYCLES cycles, then enter IDLE.
REQ-020 done SHALL be high for exactly the first IDLE cycle after a completed frame.
REQ-021 busy SHALL be low in the done cycle, so a start in that cycle SHALL be accepted; this gives back-to-back frames.
REQ-022 start while busy=1 SHALL be ignored with no effect on the frame in progress.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with dout=0, valid=0, busy=0 and no done pulse.
REQ-024 abort in IDLE SHALL have no effect; abort SHALL take priority over start in the same cycle.
REQ-025 The code and len inputs SHALL be ignored after capture; changing them mid-frame SHALL not alter the frame.
REQ-026 In IDLE, dout, valid and busy SHALL be 0.

Reset
REQ-027 arst=0 at a clock edge SHALL force IDLE, dout=0, valid=0, busy=0, done=0, and clear the latched code/len and counters.
REQ-028 Reset mid-frame SHALL truncate the frame immediately with no done pulse.
REQ-029 Reset SHALL take priority over abort and start.

Configuration
REQ-030 Macro CODE_SERIALIZER_PARITY_EN SHALL control the parity bit.
REQ-031 With CODE_SERIALIZER_PARITY_EN defined, PARITY SHALL emit one bit (valid=1) that is the even parity (XOR) of the len transmitted bits, immediately after the last code bit.
REQ-032 With CODE_SERIALIZER_PARITY_EN undefined, the PARITY state and its logic SHALL be absent and SHIFT SHALL go straight to GAP.
REQ-033 The port list SHALL be identical in both builds.

Verification
REQ-034 Parity off, GAP_CYCLES=2, code=8'hCA, len=8, start at cycle 0 -> dout=1,1,0,0,1,0,1,0 with valid=1 in cycles 1-8; dout=0, valid=0, busy=1 in cycles 9-10; done=1, busy=0 in cycle 11.
REQ-035 Parity on, same stimulus -> parity bit 0 in cycle 9; gap in cycles 10-11; done in cycle 12. With code=8'hCB, the parity bit is 1.
REQ-036 code=8'hA5, len=4 -> dout=0,1,0,1 in cycles 1-4; len=0 -> busy stays 0 and no done; len=12 -> exactly 8 bits sent.
REQ-037 start pulsed at cycles 3 and 5 during a frame -> ignored; start held high -> back-to-back frames, each start accepted in the done cycle.
REQ-038 abort at cycle 4 -> IDLE at cycle 5 with no done; arst=0 at cycle 6 of a frame -> all outputs 0 at the next edge; a new start after release works normally.
